// File: rtl/pipeline_control_pkg.sv
// Shared widths, MIPS opcode constants and the control bundles carried down the pipe.
package pipeline_control_pkg;

  localparam int OPCODE_WIDTH = 6;
  localparam int FUNCT_WIDTH  = 6;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = 6'h2B;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_WIDTH-1:0] OP_SLTI  = 6'h0A;
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI  = 6'h0C;
  localparam logic [OPCODE_WIDTH-1:0] OP_ORI   = 6'h0D;

  typedef struct packed {
    logic reg_dst;
    logic alu_src;
    logic mem_rd;
    logic mem_wr;
    logic reg_wr;
    logic mem_to_reg;
    logic branch;
    logic uses_rt;
    logic illegal;
  } ctrl_t;

  // Narrower bundles: each stage keeps only the bits still needed downstream.
  typedef struct packed {
    logic reg_dst;
    logic alu_src;
    logic mem_rd;
    logic mem_wr;
    logic reg_wr;
    logic mem_to_reg;
    logic branch;
    logic illegal;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_rd;
    logic mem_wr;
    logic reg_wr;
    logic mem_to_reg;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_wr;
    logic mem_to_reg;
  } wb_ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipeline_control_decoder.sv
// Combinational opcode-to-control table for the ID stage.
module control_decoder
  import pipeline_control_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output ctrl_t                   ctrl
);

  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode)
      OP_RTYPE: begin
        ctrl.reg_dst = 1'b1;
        ctrl.reg_wr  = 1'b1;
        ctrl.uses_rt = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_rd     = 1'b1;
        ctrl.reg_wr     = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src = 1'b1;
        ctrl.mem_wr  = 1'b1;
        ctrl.uses_rt = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch  = 1'b1;
        ctrl.uses_rt = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: begin
        ctrl.alu_src = 1'b1;
        ctrl.reg_wr  = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pipeline_control.sv
// MIPS 5-stage control pipe: ID decode, ID/EX-EX/MEM-MEM/WB control registers,
// load-use stall and taken-beq flush.
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int AWIDTH = 5
) (
  input  logic                    d_clk,
  input  logic                    d_rst,
  input  logic                    c_i_valid,
  input  logic [OPCODE_WIDTH-1:0] c_i_opcode,
  input  logic [FUNCT_WIDTH-1:0]  c_i_funct,
  input  logic [AWIDTH-1:0]       c_i_rs,
  input  logic [AWIDTH-1:0]       c_i_rt,
  input  logic [AWIDTH-1:0]       c_i_rd,
  input  logic                    c_i_ex_zero,
  output logic                    c_o_ex_alu_src,
  output logic                    c_o_ex_reg_dst,
  output logic [OPCODE_WIDTH-1:0] c_o_ex_alu_op,
  output logic [FUNCT_WIDTH-1:0]  c_o_ex_alu_funct,
  output logic                    c_o_mem_rd,
  output logic                    c_o_mem_wr,
  output logic                    c_o_wb_reg_wr,
  output logic                    c_o_wb_mem_to_reg,
  output logic [AWIDTH-1:0]       c_o_wb_dst,
  output logic                    c_o_stall,
  output logic                    c_o_flush,
  output logic                    c_o_pc_src,
  output logic                    c_o_illegal
);

  ctrl_t            dec_ctrl;
  ex_ctrl_t         id_ctrl;
  logic [AWIDTH-1:0] id_dst;
  logic             load_use;
  logic             flush;
  logic             id_take;

  ex_ctrl_t                ctrl_p0;
  logic [OPCODE_WIDTH-1:0] op_p0;
  logic [FUNCT_WIDTH-1:0]  funct_p0;
  logic [AWIDTH-1:0]       dst_p0;
  logic                    vld_p0;
  mem_ctrl_t               ctrl_p1;
  logic [AWIDTH-1:0]       dst_p1;
  logic                    vld_p1;
  wb_ctrl_t                ctrl_p2;
  logic [AWIDTH-1:0]       dst_p2;
  logic                    vld_p2;

  control_decoder u_decoder (
    .opcode (c_i_opcode),
    .ctrl   (dec_ctrl)
  );

  // An illegal opcode travels as a NOP: no destination, no writes.
  always_comb begin
    id_dst = dec_ctrl.illegal ? '0 : (dec_ctrl.reg_dst ? c_i_rd : c_i_rt);
    id_ctrl = '{reg_dst:    dec_ctrl.reg_dst,
                alu_src:    dec_ctrl.alu_src,
                mem_rd:     dec_ctrl.mem_rd,
                mem_wr:     dec_ctrl.mem_wr,
                reg_wr:     dec_ctrl.reg_wr & (id_dst != '0),
                mem_to_reg: dec_ctrl.mem_to_reg,
                branch:     dec_ctrl.branch,
                illegal:    dec_ctrl.illegal};
  end

  assign flush    = vld_p0 & ctrl_p0.branch & c_i_ex_zero;
  assign load_use = c_i_valid & vld_p0 & ctrl_p0.mem_rd & (dst_p0 != '0) &
                    ((dst_p0 == c_i_rs) | (dec_ctrl.uses_rt & (dst_p0 == c_i_rt)));
  assign id_take  = c_i_valid & ~flush & ~load_use;

  always_ff @(posedge d_clk or negedge d_rst) begin
    if (!d_rst) begin
      vld_p0   <= 1'b0;
      ctrl_p0  <= '0;
      op_p0    <= '0;
      funct_p0 <= '0;
      dst_p0   <= '0;
      vld_p1   <= 1'b0;
      ctrl_p1  <= '0;
      dst_p1   <= '0;
      vld_p2   <= 1'b0;
      ctrl_p2  <= '0;
      dst_p2   <= '0;
    end else begin
      // ID -> EX
      vld_p0   <= id_take;
      ctrl_p0  <= id_ctrl;
      op_p0    <= dec_ctrl.illegal ? '0 : c_i_opcode;
      funct_p0 <= dec_ctrl.illegal ? '0 : c_i_funct;
      dst_p0   <= id_dst;
      // EX -> MEM
      vld_p1   <= vld_p0;
      ctrl_p1  <= {ctrl_p0.mem_rd, ctrl_p0.mem_wr, ctrl_p0.reg_wr, ctrl_p0.mem_to_reg};
      dst_p1   <= dst_p0;
      // MEM -> WB
      vld_p2   <= vld_p1;
      ctrl_p2  <= {ctrl_p1.reg_wr, ctrl_p1.mem_to_reg};
      dst_p2   <= dst_p1;
    end
  end

  assign c_o_ex_alu_src    = vld_p0 & ctrl_p0.alu_src;
  assign c_o_ex_reg_dst    = vld_p0 & ctrl_p0.reg_dst;
  assign c_o_ex_alu_op     = vld_p0 ? op_p0 : '0;
  assign c_o_ex_alu_funct  = vld_p0 ? funct_p0 : '0;
  assign c_o_illegal       = vld_p0 & ctrl_p0.illegal;
  assign c_o_mem_rd        = vld_p1 & ctrl_p1.mem_rd;
  assign c_o_mem_wr        = vld_p1 & ctrl_p1.mem_wr;
  assign c_o_wb_reg_wr     = vld_p2 & ctrl_p2.reg_wr;
  assign c_o_wb_mem_to_reg = vld_p2 & ctrl_p2.mem_to_reg;
  assign c_o_wb_dst        = vld_p2 ? dst_p2 : '0;
  assign c_o_stall         = load_use & ~flush;
  assign c_o_flush         = flush;
  assign c_o_pc_src        = flush;

endmodule

// File: tb/tb_pipeline_control.sv
// Scoreboard bench: each driven cycle queues the hand-derived outputs for that cycle.
module tb_pipeline_control;

  typedef struct packed {
    logic       src;
    logic       rdst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       mrd;
    logic       mwr;
    logic       wbw;
    logic       m2r;
    logic [4:0] dst;
    logic       stl;
    logic       fl;
    logic       pcs;
    logic       ill;
  } obs_t;

  typedef struct {
    int   idx;
    obs_t e;
  } sb_t;

  localparam obs_t Z = '0;

  logic       d_clk;
  logic       d_rst;
  logic       c_i_valid;
  logic [5:0] c_i_opcode;
  logic [5:0] c_i_funct;
  logic [4:0] c_i_rs;
  logic [4:0] c_i_rt;
  logic [4:0] c_i_rd;
  logic       c_i_ex_zero;
  logic       c_o_ex_alu_src;
  logic       c_o_ex_reg_dst;
  logic [5:0] c_o_ex_alu_op;
  logic [5:0] c_o_ex_alu_funct;
  logic       c_o_mem_rd;
  logic       c_o_mem_wr;
  logic       c_o_wb_reg_wr;
  logic       c_o_wb_mem_to_reg;
  logic [4:0] c_o_wb_dst;
  logic       c_o_stall;
  logic       c_o_flush;
  logic       c_o_pc_src;
  logic       c_o_illegal;

  obs_t act;
  sb_t  sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cidx  = 0;

  pipeline_control dut (
    .d_clk             (d_clk),
    .d_rst             (d_rst),
    .c_i_valid         (c_i_valid),
    .c_i_opcode        (c_i_opcode),
    .c_i_funct         (c_i_funct),
    .c_i_rs            (c_i_rs),
    .c_i_rt            (c_i_rt),
    .c_i_rd            (c_i_rd),
    .c_i_ex_zero       (c_i_ex_zero),
    .c_o_ex_alu_src    (c_o_ex_alu_src),
    .c_o_ex_reg_dst    (c_o_ex_reg_dst),
    .c_o_ex_alu_op     (c_o_ex_alu_op),
    .c_o_ex_alu_funct  (c_o_ex_alu_funct),
    .c_o_mem_rd        (c_o_mem_rd),
    .c_o_mem_wr        (c_o_mem_wr),
    .c_o_wb_reg_wr     (c_o_wb_reg_wr),
    .c_o_wb_mem_to_reg (c_o_wb_mem_to_reg),
    .c_o_wb_dst        (c_o_wb_dst),
    .c_o_stall         (c_o_stall),
    .c_o_flush         (c_o_flush),
    .c_o_pc_src        (c_o_pc_src),
    .c_o_illegal       (c_o_illegal)
  );

  initial d_clk = 1'b0;
  always #5 d_clk = ~d_clk;

  assign act = '{src: c_o_ex_alu_src, rdst: c_o_ex_reg_dst, op: c_o_ex_alu_op,
                 fn: c_o_ex_alu_funct, mrd: c_o_mem_rd, mwr: c_o_mem_wr,
                 wbw: c_o_wb_reg_wr, m2r: c_o_wb_mem_to_reg, dst: c_o_wb_dst,
                 stl: c_o_stall, fl: c_o_flush, pcs: c_o_pc_src, ill: c_o_illegal};

  function automatic obs_t ev(input logic src, input logic rdst,
                              input logic [5:0] op, input logic [5:0] fn,
                              input logic mrd, input logic mwr,
                              input logic wbw, input logic m2r,
                              input logic [4:0] dst, input logic stl,
                              input logic fl, input logic ill);
    obs_t o;
    o = '{src: src, rdst: rdst, op: op, fn: fn, mrd: mrd, mwr: mwr, wbw: wbw,
          m2r: m2r, dst: dst, stl: stl, fl: fl, pcs: fl, ill: ill};
    return o;
  endfunction

  task automatic cyc(input logic rn, input logic v, input logic [5:0] op,
                     input logic [5:0] fn, input logic [4:0] rs,
                     input logic [4:0] rt, input logic [4:0] rd,
                     input logic z, input obs_t e);
    sb_t item;
    @(posedge d_clk);
    #1;
    d_rst       = rn;
    c_i_valid   = v;
    c_i_opcode  = op;
    c_i_funct   = fn;
    c_i_rs      = rs;
    c_i_rt      = rt;
    c_i_rd      = rd;
    c_i_ex_zero = z;
    item.idx = cidx;
    item.e   = e;
    sbq.push_back(item);
    cidx++;
  endtask

  task automatic idle(input obs_t e);
    cyc(1'b1, 1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, e);
  endtask

  always @(negedge d_clk) begin
    if (sbq.size() > 0) begin
      sb_t item;
      item = sbq.pop_front();
      total++;
      if (act !== item.e) begin
        bad++;
        $display("FAIL cyc%0d outputs: got %h want %h (src,rdst,op,fn,mrd,mwr,wbw,m2r,dst,stl,fl,pcs,ill)",
                 item.idx, act, item.e);
      end
    end
  end

  initial begin
    d_rst = 1'b0; c_i_valid = 1'b0; c_i_opcode = '0; c_i_funct = '0;
    c_i_rs = '0; c_i_rt = '0; c_i_rd = '0; c_i_ex_zero = 1'b0;

    // reset held with a valid lw in ID, then release
    cyc(0, 1, 6'h23, 6'h00, 1, 8, 0, 0, Z);
    cyc(0, 1, 6'h23, 6'h00, 1, 8, 0, 0, Z);
    cyc(1, 1, 6'h23, 6'h00, 1, 8, 0, 0, Z);
    idle(ev(1, 0, 6'h23, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    idle(ev(0, 0, 6'h00, 6'h00, 1, 0, 0, 0, 0, 0, 0, 0));
    idle(ev(0, 0, 6'h00, 6'h00, 0, 0, 1, 1, 8, 0, 0, 0));

    // lw $8 then add $9,$8,$10: one stall cycle
    cyc(1, 1, 6'h23, 6'h00, 2, 8, 0, 0, Z);
    cyc(1, 1, 6'h00, 6'h20, 8, 10, 9, 0, ev(1, 0, 6'h23, 6'h00, 0, 0, 0, 0, 0, 1, 0, 0));
    cyc(1, 1, 6'h00, 6'h20, 8, 10, 9, 0, ev(0, 0, 6'h00, 6'h00, 1, 0, 0, 0, 0, 0, 0, 0));
    idle(ev(0, 1, 6'h00, 6'h20, 0, 0, 1, 1, 8, 0, 0, 0));
    idle(Z);
    idle(ev(0, 0, 6'h00, 6'h00, 0, 0, 1, 0, 9, 0, 0, 0));

    // taken beq squashes the following addi
    cyc(1, 1, 6'h04, 6'h00, 1, 2, 0, 0, Z);
    cyc(1, 1, 6'h08, 6'h00, 3, 4, 0, 1, ev(0, 0, 6'h04, 6'h00, 0, 0, 0, 0, 0, 0, 1, 0));
    idle(Z);
    idle(ev(0, 0, 6'h00, 6'h00, 0, 0, 0, 0, 2, 0, 0, 0));
    idle(Z);

    // untaken beq lets the following ori through
    cyc(1, 1, 6'h04, 6'h00, 1, 2, 0, 0, Z);
    cyc(1, 1, 6'h0D, 6'h00, 1, 5, 0, 0, ev(0, 0, 6'h04, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    idle(ev(1, 0, 6'h0D, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    idle(ev(0, 0, 6'h00, 6'h00, 0, 0, 0, 0, 2, 0, 0, 0));
    idle(ev(0, 0, 6'h00, 6'h00, 0, 0, 1, 0, 5, 0, 0, 0));

    // addi $0 never writes; sw writes memory only
    cyc(1, 1, 6'h08, 6'h00, 1, 0, 0, 0, Z);
    cyc(1, 1, 6'h2B, 6'h00, 1, 6, 0, 0, ev(1, 0, 6'h08, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    idle(ev(1, 0, 6'h2B, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    idle(ev(0, 0, 6'h00, 6'h00, 0, 1, 0, 0, 0, 0, 0, 0));
    idle(ev(0, 0, 6'h00, 6'h00, 0, 0, 0, 0, 6, 0, 0, 0));

    // illegal opcode 0x3F
    cyc(1, 1, 6'h3F, 6'h00, 1, 7, 0, 0, Z);
    idle(ev(0, 0, 6'h00, 6'h00, 0, 0, 0, 0, 0, 0, 0, 1));
    idle(Z);
    idle(Z);

    // load-use with ex_zero high: no flush, then async reset mid-stream
    cyc(1, 1, 6'h23, 6'h00, 1, 8, 0, 0, Z);
    cyc(1, 1, 6'h00, 6'h20, 8, 3, 9, 1, ev(1, 0, 6'h23, 6'h00, 0, 0, 0, 0, 0, 1, 0, 0));
    cyc(1, 1, 6'h00, 6'h20, 8, 3, 9, 0, ev(0, 0, 6'h00, 6'h00, 1, 0, 0, 0, 0, 0, 0, 0));
    cyc(0, 0, 6'h00, 6'h00, 0, 0, 0, 0, Z);
    cyc(0, 1, 6'h23, 6'h00, 1, 8, 0, 0, Z);
    cyc(1, 1, 6'h23, 6'h00, 1, 8, 0, 0, Z);
    idle(ev(1, 0, 6'h23, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    idle(ev(0, 0, 6'h00, 6'h00, 1, 0, 0, 0, 0, 0, 0, 0));
    idle(ev(0, 0, 6'h00, 6'h00, 0, 0, 1, 1, 8, 0, 0, 0));

    // addi reads rs only: matching rt must not stall
    cyc(1, 1, 6'h23, 6'h00, 1, 8, 0, 0, Z);
    cyc(1, 1, 6'h08, 6'h00, 2, 8, 0, 0, ev(1, 0, 6'h23, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    idle(ev(1, 0, 6'h08, 6'h00, 1, 0, 0, 0, 0, 0, 0, 0));
    idle(ev(0, 0, 6'h00, 6'h00, 0, 0, 1, 1, 8, 0, 0, 0));
    idle(ev(0, 0, 6'h00, 6'h00, 0, 0, 1, 0, 8, 0, 0, 0));
    idle(Z);

    for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge d_clk);
    #1;
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending entries want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
